// File: rtl/bcd_time_counter_24b_if.sv
// Control and data bundle for the BCD time-of-day counter.
// The master side drives the controls; the slave side is the counter.
interface bcd_time_counter_24b_if;
  logic        tick;
  logic        en;
  logic        load;
  logic [23:0] load_val;
  logic        inc;
  logic [1:0]  inc_sel;
  logic [23:0] out;
  logic        day_carry;
  logic        load_err;

  modport master (
    output tick, en, load, load_val, inc, inc_sel,
    input  out, day_carry, load_err
  );

  modport slave (
    input  tick, en, load, load_val, inc, inc_sel,
    output out, day_carry, load_err
  );
endinterface

// File: rtl/bcd_time_counter_24b.sv
// Six-digit BCD HH:MM:SS counter with tick advance, checked parallel load,
// per-field adjust and a day-rollover pulse.
module bcd_time_counter_24b #(
  parameter logic [7:0]  HOURS_MAX = 8'h23,
  parameter logic [23:0] RESET_VAL = 24'h00_00_00
) (
  input  logic                   clk,
  input  logic                   rst,
  bcd_time_counter_24b_if.slave  bus
);

  logic [23:0] out_reg, out_next;
  logic        day_carry_reg, day_carry_next;
  logic        load_err_reg, load_err_next;

  logic [7:0]  hours, minutes, seconds;
  logic [7:0]  hour_next, min_next, sec_next;
  logic        hour_wrap, min_wrap, sec_wrap;
  logic [5:0]  digit_ok;
  logic        load_ok;

  // Minutes and seconds share the same 00..59 BCD wrap.
  function automatic logic [7:0] inc_59(input logic [7:0] f);
    if (f[3:0] == 4'd9)
      inc_59 = (f[7:4] == 4'd5) ? 8'h00 : {f[7:4] + 4'd1, 4'd0};
    else
      inc_59 = {f[7:4], f[3:0] + 4'd1};
  endfunction

  assign hours   = out_reg[23:16];
  assign minutes = out_reg[15:8];
  assign seconds = out_reg[7:0];

  assign sec_wrap  = (seconds == 8'h59);
  assign min_wrap  = (minutes == 8'h59);
  assign hour_wrap = (hours == HOURS_MAX);

  assign sec_next  = inc_59(seconds);
  assign min_next  = inc_59(minutes);
  assign hour_next = hour_wrap ? 8'h00 :
                     (hours[3:0] == 4'd9) ? {hours[7:4] + 4'd1, 4'd0} :
                                            {hours[7:4], hours[3:0] + 4'd1};

  // Tens-of-seconds and tens-of-minutes digits stop at 5, all others at 9.
  for (genvar gi = 0; gi < 6; gi++) begin : g_digit_check
    assign digit_ok[gi] = bus.load_val[4*gi +: 4] <=
                          ((gi == 1 || gi == 3) ? 4'd5 : 4'd9);
  end

  assign load_ok = (&digit_ok) && (bus.load_val[23:16] <= HOURS_MAX);

  always_comb begin
    out_next       = out_reg;
    day_carry_next = 1'b0;
    load_err_next  = 1'b0;
    if (bus.load) begin
      if (load_ok)
        out_next = bus.load_val;
      else
        load_err_next = 1'b1;
    end else if (bus.inc && bus.inc_sel != 2'b00) begin
      case (bus.inc_sel)
        2'b01:   out_next = {hours, minutes, sec_next};
        2'b10:   out_next = {hours, min_next, seconds};
        default: out_next = {hour_next, minutes, seconds};
      endcase
    end else if (bus.tick && bus.en) begin
      out_next = {(sec_wrap && min_wrap) ? hour_next : hours,
                  sec_wrap ? min_next : minutes,
                  sec_next};
      day_carry_next = sec_wrap && min_wrap && hour_wrap;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_reg       <= RESET_VAL;
      day_carry_reg <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      out_reg       <= out_next;
      day_carry_reg <= day_carry_next;
      load_err_reg  <= load_err_next;
    end
  end

  assign bus.out       = out_reg;
  assign bus.day_carry = day_carry_reg;
  assign bus.load_err  = load_err_reg;

endmodule

// File: tb/tb_bcd_time_counter_24b.sv
// Directed-vector bench: the driver queues the expected state for each cycle
// it drives, and a monitor compares the registered outputs after the edge.
module tb_bcd_time_counter_24b;

  typedef struct {
    string       name;
    logic [23:0] out;
    logic        dc;
    logic        le;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  bcd_time_counter_24b_if bus ();

  bcd_time_counter_24b #(
    .HOURS_MAX (8'h23),
    .RESET_VAL (24'h00_00_00)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs and queue what the outputs must be after the edge.
  task automatic step(input string name, input logic r, input logic tk,
                      input logic e, input logic ld, input logic [23:0] lv,
                      input logic ic, input logic [1:0] sel,
                      input logic [23:0] exp_out, input logic exp_dc,
                      input logic exp_le);
    exp_t x;
    rst          = r;
    bus.tick     = tk;
    bus.en       = e;
    bus.load     = ld;
    bus.load_val = lv;
    bus.inc      = ic;
    bus.inc_sel  = sel;
    x.name = name;
    x.out  = exp_out;
    x.dc   = exp_dc;
    x.le   = exp_le;
    sb.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: outputs are registered, so every driven cycle yields one result.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (bus.out !== e.out || bus.day_carry !== e.dc || bus.load_err !== e.le) begin
          n_fail++;
          $display("FAIL %s: got out=%h dc=%b le=%b, want out=%h dc=%b le=%b",
                   e.name, bus.out, bus.day_carry, bus.load_err, e.out, e.dc, e.le);
        end else begin
          $display("ok   %s: out=%h dc=%b le=%b", e.name, bus.out,
                   bus.day_carry, bus.load_err);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    bus.tick = 1'b0; bus.en = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.inc = 1'b0; bus.inc_sel = 2'b00;
    @(negedge clk);

    //   name            rst tk en ld load_val     inc sel   exp_out      dc le
    step("reset",        1, 0, 0, 0, 24'h000000, 0, 2'b00, 24'h000000, 0, 0);
    step("load_235958",  0, 0, 1, 1, 24'h235958, 0, 2'b00, 24'h235958, 0, 0);
    step("tick_235959",  0, 1, 1, 0, 24'h000000, 0, 2'b00, 24'h235959, 0, 0);
    step("tick_dayroll", 0, 1, 1, 0, 24'h000000, 0, 2'b00, 24'h000000, 1, 0);
    step("idle_dc_low",  0, 0, 1, 0, 24'h000000, 0, 2'b00, 24'h000000, 0, 0);

    step("load_120959",  0, 0, 1, 1, 24'h120959, 0, 2'b00, 24'h120959, 0, 0);
    step("tick_121000",  0, 1, 1, 0, 24'h000000, 0, 2'b00, 24'h121000, 0, 0);
    step("load_095959",  0, 0, 1, 1, 24'h095959, 0, 2'b00, 24'h095959, 0, 0);
    step("tick_100000",  0, 1, 1, 0, 24'h000000, 0, 2'b00, 24'h100000, 0, 0);
    step("load_195959",  0, 0, 1, 1, 24'h195959, 0, 2'b00, 24'h195959, 0, 0);
    step("tick_200000",  0, 1, 1, 0, 24'h000000, 0, 2'b00, 24'h200000, 0, 0);

    step("rej_240000",   0, 0, 1, 1, 24'h240000, 0, 2'b00, 24'h200000, 0, 1);
    step("rej_126a00",   0, 0, 1, 1, 24'h126A00, 0, 2'b00, 24'h200000, 0, 1);
    step("rej_1a0000",   0, 0, 1, 1, 24'h1A0000, 0, 2'b00, 24'h200000, 0, 1);
    step("rej_120060",   0, 0, 1, 1, 24'h120060, 0, 2'b00, 24'h200000, 0, 1);
    step("load_073015",  0, 0, 1, 1, 24'h073015, 0, 2'b00, 24'h073015, 0, 0);

    step("load_105959",  0, 0, 1, 1, 24'h105959, 0, 2'b00, 24'h105959, 0, 0);
    step("inc_min_wrap", 0, 0, 1, 0, 24'h000000, 1, 2'b10, 24'h100059, 0, 0);
    step("load_234512",  0, 0, 1, 1, 24'h234512, 0, 2'b00, 24'h234512, 0, 0);
    step("inc_hr_wrap",  0, 0, 1, 0, 24'h000000, 1, 2'b11, 24'h004512, 0, 0);
    step("inc_hr_09",    0, 0, 1, 1, 24'h095959, 0, 2'b00, 24'h095959, 0, 0);
    step("inc_hr_10",    0, 0, 1, 0, 24'h000000, 1, 2'b11, 24'h105959, 0, 0);
    step("inc_sec_wrap", 0, 0, 1, 0, 24'h000000, 1, 2'b01, 24'h105900, 0, 0);
    step("inc_sel0_tick",0, 1, 1, 0, 24'h000000, 1, 2'b00, 24'h105901, 0, 0);

    step("load_beats_all",0, 1, 1, 1, 24'h010203, 1, 2'b01, 24'h010203, 0, 0);
    step("load_000010",  0, 0, 1, 1, 24'h000010, 0, 2'b00, 24'h000010, 0, 0);
    step("inc_beats_tick",0, 1, 1, 0, 24'h000000, 1, 2'b01, 24'h000011, 0, 0);

    for (int i = 0; i < 10; i++)
      step($sformatf("hold_%0d", i), 0, 1, 0, 0, 24'h000000, 0, 2'b00,
           24'h000011, 0, 0);
    step("run_000012",   0, 1, 1, 0, 24'h000000, 0, 2'b00, 24'h000012, 0, 0);
    step("run_000013",   0, 1, 1, 0, 24'h000000, 0, 2'b00, 24'h000013, 0, 0);
    step("rst_mid_tick", 1, 1, 1, 1, 24'h121212, 1, 2'b11, 24'h000000, 0, 0);
    step("after_rst",    0, 1, 1, 0, 24'h000000, 0, 2'b00, 24'h000001, 0, 0);

    bus.tick = 1'b0; bus.load = 1'b0; bus.inc = 1'b0;
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain: %0d results still pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation time limit reached, want completion");
    $fatal(1, "timeout");
  end

endmodule
